// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch unit: FSM states, next-PC source
// selector and a width-generic sign-extension function.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef enum logic [2:0] {
        SRC_HALT    = 3'd0,
        SRC_JR      = 3'd1,
        SRC_CALL    = 3'd2,
        SRC_RET     = 3'd3,
        SRC_RET_UNF = 3'd4,
        SRC_BR      = 3'd5,
        SRC_SEQ     = 3'd6
    } npc_src_e;

    localparam int unsigned SEXT_W = 32;

    // Replicate bit w-1 of val into every bit above it.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] val,
                                               input int unsigned w);
        logic [SEXT_W-1:0] hi_mask;
        hi_mask = {SEXT_W{1'b1}} << w;
        if (val[w - 32'd1]) begin
            sext = val | hi_mask;
        end else begin
            sext = val & ~hi_mask;
        end
    endfunction

endpackage

// File: rtl/fetch_unit_ret_stack.sv
// Circular return-address stack; a push while full silently replaces the
// oldest entry so the most recent RAS_DEPTH return addresses survive.
module ret_stack #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned PC_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PC_W-1:0]  mem_d [RAS_DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] rd_ptr_s;

    assign rd_ptr_s = wr_ptr_q - IDX_W'(1);
    assign top      = mem_q[rd_ptr_s];
    assign empty    = (count_q == CNT_W'(0));
    assign full     = (count_q == DEPTH_CNT);

    // Pointer wraps naturally because the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + IDX_W'(1);
            count_d         = full ? count_q : (count_q + CNT_W'(1));
        end else if (pop && !empty) begin
            wr_ptr_d = rd_ptr_s;
            count_d  = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= IDX_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and instruction fetch: FETCH/HOLD/HALTED state machine,
// prioritised redirects and a return-address stack.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W       = 16,
    parameter int unsigned     BR_OFF_W   = 9,
    parameter int unsigned     CALL_OFF_W = 12,
    parameter int unsigned     RAS_DEPTH  = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_ack,
    input  logic [15:0]           imem_data,
    output logic                  instr_valid,
    output logic [15:0]           instr,
    output logic [PC_W-1:0]       instr_pc,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [BR_OFF_W-1:0]   br_off,
    input  logic                  jr_en,
    input  logic [PC_W-1:0]       jr_target,
    input  logic                  call_en,
    input  logic [CALL_OFF_W-1:0] call_off,
    input  logic                  ret_en,
    input  logic                  halt_req,
    output logic [PC_W-1:0]       pc,
    output logic                  hlt,
    output logic                  ras_ovf,
    output logic                  ras_unf
);
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d;
    logic [15:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d, hlt_q, hlt_d;
    logic            ras_ovf_q, ras_ovf_d, ras_unf_q, ras_unf_d;
    logic            consume_s, push_s, pop_s, ras_empty_s, ras_full_s;
    logic [PC_W-1:0] ras_top_s, pc_inc_s, br_tgt_s, call_tgt_s;
    npc_src_e        npc_src_s;

    assign consume_s  = (state_q == ST_HOLD) && instr_valid_q && !stall;
    assign pc_inc_s   = pc_q + PC_W'(1);
    assign br_tgt_s   = pc_inc_s + PC_W'(sext(SEXT_W'(br_off), BR_OFF_W));
    assign call_tgt_s = pc_inc_s + PC_W'(sext(SEXT_W'(call_off), CALL_OFF_W));

    // Redirect priority; only acted upon in the consume cycle.
    always_comb begin
        if (halt_req) begin
            npc_src_s = SRC_HALT;
        end else if (jr_en) begin
            npc_src_s = SRC_JR;
        end else if (call_en) begin
            npc_src_s = SRC_CALL;
        end else if (ret_en) begin
            npc_src_s = ras_empty_s ? SRC_RET_UNF : SRC_RET;
        end else if (br_taken) begin
            npc_src_s = SRC_BR;
        end else begin
            npc_src_s = SRC_SEQ;
        end
    end

    ret_stack #(
        .RAS_DEPTH(RAS_DEPTH),
        .PC_W     (PC_W)
    ) u_ret_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .push_data(pc_inc_s),
        .top      (ras_top_s),
        .empty    (ras_empty_s),
        .full     (ras_full_s)
    );

    // State, PC and instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_pc_q    <= PC_W'(0);
            instr_valid_q <= 1'b0;
            hlt_q         <= 1'b0;
            ras_ovf_q     <= 1'b0;
            ras_unf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            hlt_q         <= hlt_d;
            ras_ovf_q     <= ras_ovf_d;
            ras_unf_q     <= ras_unf_d;
        end
    end

    // Next-state and next-PC logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        hlt_d         = hlt_q;
        ras_ovf_d     = ras_ovf_q;
        ras_unf_d     = ras_unf_q;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    instr_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (consume_s) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                    case (npc_src_s)
                        SRC_HALT: begin
                            state_d = ST_HALTED;
                            hlt_d   = 1'b1;
                        end
                        SRC_JR:   pc_d = jr_target;
                        SRC_CALL: begin
                            pc_d      = call_tgt_s;
                            push_s    = 1'b1;
                            ras_ovf_d = ras_ovf_q | ras_full_s;
                        end
                        SRC_RET: begin
                            pc_d  = ras_top_s;
                            pop_s = 1'b1;
                        end
                        SRC_RET_UNF: begin
                            pc_d      = pc_inc_s;
                            ras_unf_d = 1'b1;
                        end
                        SRC_BR:   pc_d = br_tgt_s;
                        default:  pc_d = pc_inc_s;
                    endcase
                end else begin
                    instr_valid_d = instr_valid_q;
                end
            end
            ST_HALTED: begin
                instr_valid_d = 1'b0;
                hlt_d         = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Output decode.
    always_comb begin
        imem_req = (state_q == ST_FETCH) && !rst;
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign hlt         = hlt_q;
    assign ras_ovf     = ras_ovf_q;
    assign ras_unf     = ras_unf_q;

endmodule
